// File: rtl/axil_master_arbiter_if.sv
// AXI-Lite bus bundle between the two-requester arbiter (master side)
// and a register-file slave.
interface axil_master_arbiter_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;

  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;

  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awvalid, input  awready,
    output wdata, wstrb, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arvalid, input  arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awvalid, output awready,
    input  wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input  bready,
    input  araddr, arvalid, output arready,
    output rdata, rresp, rvalid, input  rready
  );
endinterface

// File: rtl/axil_master_arbiter.sv
// Two-requester round-robin arbiter onto one AXI-Lite master port.
// One transaction in flight at a time; error responses are counted.
module axil_master_arbiter #(
  parameter  int ADDR_WIDTH = 12,
  parameter  int DATA_WIDTH = 32,
  localparam int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [1:0]              req_valid,
  input  logic [1:0]              req_write,
  input  logic [2*ADDR_WIDTH-1:0] req_addr,
  input  logic [2*DATA_WIDTH-1:0] req_wdata,
  input  logic [2*STRB_WIDTH-1:0] req_wstrb,
  output logic [1:0]              req_ack,
  output logic [1:0]              rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    busy,
  output logic [7:0]              err_count,
  axil_master_arbiter_if.master   m_axil
);

  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE
  } state_t;

  state_t                state, state_next;
  logic                  grant, grant_next, last_grant;
  logic                  capture;
  logic                  aw_done, w_done, aw_fire, w_fire;
  logic                  resp_take;
  logic [1:0]            resp_in;
  logic [ADDR_WIDTH-1:0] addr_hold;
  logic [DATA_WIDTH-1:0] wdata_hold;
  logic [STRB_WIDTH-1:0] wstrb_hold;
  logic [DATA_WIDTH-1:0] rdata_hold;
  logic [1:0]            resp_hold;

  assign capture   = (state == IDLE) && (req_valid != 2'b00);
  assign aw_fire   = m_axil.awvalid && m_axil.awready;
  assign w_fire    = m_axil.wvalid && m_axil.wready;
  assign resp_take = ((state == WR_RESP) && m_axil.bvalid) ||
                     ((state == RD_DATA) && m_axil.rvalid);
  assign resp_in   = (state == RD_DATA) ? m_axil.rresp : m_axil.bresp;

  // Payload and response always come straight from the holding registers.
  assign m_axil.awaddr = addr_hold;
  assign m_axil.araddr = addr_hold;
  assign m_axil.wdata  = wdata_hold;
  assign m_axil.wstrb  = wstrb_hold;
  assign rsp_rdata     = rdata_hold;
  assign rsp_resp      = resp_hold;

  // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    grant_next = last_grant;
    case (req_valid)
      2'b01:   grant_next = 1'b0;
      2'b10:   grant_next = 1'b1;
      2'b11:   grant_next = ~last_grant;
      default: grant_next = last_grant;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; write leaves WR_REQ once both AW and W have handshaked.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (capture) state_next = req_write[grant_next] ? WR_REQ : RD_REQ;
      WR_REQ:  if ((aw_done || aw_fire) && (w_done || w_fire)) state_next = WR_RESP;
      WR_RESP: if (m_axil.bvalid) state_next = DONE;
      RD_REQ:  if (m_axil.arready) state_next = RD_DATA;
      RD_DATA: if (m_axil.rvalid) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state and registered flags only (no AXI input to AXI output path).
  always_comb begin
    m_axil.awvalid = (state == WR_REQ) && !aw_done;
    m_axil.wvalid  = (state == WR_REQ) && !w_done;
    m_axil.bready  = (state == WR_RESP);
    m_axil.arvalid = (state == RD_REQ);
    m_axil.rready  = (state == RD_DATA);
    busy           = (state != IDLE);
    req_ack        = 2'b00;
    if (capture && !rst) req_ack[grant_next] = 1'b1;
    rsp_valid      = 2'b00;
    if (state == DONE) rsp_valid[grant] = 1'b1;
  end

  // Capture the granted payload, track per-channel handshakes, latch the response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      addr_hold  <= '0;
      wdata_hold <= '0;
      wstrb_hold <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      rdata_hold <= '0;
      resp_hold  <= 2'b00;
    end else begin
      if (capture) begin
        grant      <= grant_next;
        last_grant <= grant_next;
        addr_hold  <= grant_next ? req_addr[ADDR_WIDTH +: ADDR_WIDTH]
                                 : req_addr[0 +: ADDR_WIDTH];
        wdata_hold <= grant_next ? req_wdata[DATA_WIDTH +: DATA_WIDTH]
                                 : req_wdata[0 +: DATA_WIDTH];
        wstrb_hold <= grant_next ? req_wstrb[STRB_WIDTH +: STRB_WIDTH]
                                 : req_wstrb[0 +: STRB_WIDTH];
        aw_done    <= 1'b0;
        w_done     <= 1'b0;
      end
      if (aw_fire) aw_done <= 1'b1;
      if (w_fire)  w_done  <= 1'b1;
      if (resp_take) begin
        rdata_hold <= (state == RD_DATA) ? m_axil.rdata : '0;
        resp_hold  <= resp_in;
      end
    end
  end

  // Saturating count of non-OKAY responses, bumped on the latching edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      err_count <= 8'd0;
    else if (resp_take && (resp_in != 2'b00) && (err_count != 8'hFF))
      err_count <= err_count + 8'd1;
  end

endmodule

// File: tb/tb_axil_master_arbiter.sv
// Scoreboard bench for axil_master_arbiter: stimulus pushes expected
// acks, AXI beats and responses; monitors and the slave model pop and compare.
`timescale 1ns/1ps
module tb_axil_master_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = '0;
  logic [1:0]      req_write = '0;
  logic [2*AW-1:0] req_addr  = '0;
  logic [2*DW-1:0] req_wdata = '0;
  logic [2*SW-1:0] req_wstrb = '0;
  logic [1:0]      req_ack, rsp_valid, rsp_resp;
  logic [DW-1:0]   rsp_rdata;
  logic            busy;
  logic [7:0]      err_count;

  axil_master_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) m_axil();

  axil_master_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ack(req_ack),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .busy(busy), .err_count(err_count), .m_axil(m_axil)
  );

  always #5 clk = ~clk;

  typedef struct { logic [1:0] who; logic [DW-1:0] rdata; logic [1:0] resp; int lat; } rsp_t;
  typedef struct { logic [AW-1:0] addr; int cycles; } aw_t;
  typedef struct { logic [DW-1:0] data; logic [SW-1:0] strb; } w_t;

  rsp_t          exp_rsp[$];
  aw_t           exp_aw[$];
  w_t            exp_w[$];
  logic [AW-1:0] exp_ar[$];
  logic [1:0]    exp_ack[$];

  int n_checks = 0, n_err = 0, n_acks = 0;
  int cyc = 0, last_ack_cyc = 0;

  int            cfg_aw_stall = 0;
  bit            cfg_b_block  = 1'b0;
  logic [1:0]    cfg_bresp    = 2'b00;
  logic [1:0]    cfg_rresp    = 2'b00;
  logic [DW-1:0] cfg_rdata    = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- AXI-Lite slave model with per-channel checks ----------------
  bit aw_seen, w_seen, ar_seen, aw_fire, w_fire, b_fire, ar_fire, r_fire;
  int aw_cyc, w_cyc;

  initial begin : slave
    m_axil.awready = 1'b0; m_axil.wready = 1'b0; m_axil.bvalid = 1'b0;
    m_axil.bresp = 2'b00;  m_axil.arready = 1'b0; m_axil.rvalid = 1'b0;
    m_axil.rdata = '0;     m_axil.rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_seen = 0; w_seen = 0; ar_seen = 0; aw_cyc = 0; w_cyc = 0;
        aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
        m_axil.awready = 1'b0; m_axil.wready = 1'b0; m_axil.bvalid = 1'b0;
        m_axil.arready = 1'b0; m_axil.rvalid = 1'b0;
      end else begin
        if (aw_fire) aw_seen = 1;
        if (w_fire)  w_seen  = 1;
        if (b_fire)  begin aw_seen = 0; w_seen = 0; end
        if (ar_fire) ar_seen = 1;
        if (r_fire)  ar_seen = 0;

        m_axil.awready = m_axil.awvalid && (aw_cyc >= cfg_aw_stall);
        m_axil.wready  = 1'b1;
        m_axil.bvalid  = aw_seen && w_seen && !cfg_b_block;
        m_axil.bresp   = cfg_bresp;
        m_axil.arready = 1'b1;
        m_axil.rvalid  = ar_seen;
        m_axil.rdata   = cfg_rdata;
        m_axil.rresp   = cfg_rresp;

        aw_fire = m_axil.awvalid && m_axil.awready;
        w_fire  = m_axil.wvalid  && m_axil.wready;
        b_fire  = m_axil.bvalid  && m_axil.bready;
        ar_fire = m_axil.arvalid && m_axil.arready;
        r_fire  = m_axil.rvalid  && m_axil.rready;

        if (m_axil.awvalid) begin
          aw_cyc++;
          if (exp_aw.size() == 0) check("aw_unexpected", exp_aw.size(), 1);
          else begin
            check("awaddr", m_axil.awaddr, exp_aw[0].addr);
            if (aw_fire) begin
              check("aw_cycles", aw_cyc, exp_aw[0].cycles);
              void'(exp_aw.pop_front());
              aw_cyc = 0;
            end
          end
        end
        if (m_axil.wvalid) begin
          w_cyc++;
          if (exp_w.size() == 0) check("w_unexpected", exp_w.size(), 1);
          else if (w_fire) begin
            check("wdata", m_axil.wdata, exp_w[0].data);
            check("wstrb", m_axil.wstrb, exp_w[0].strb);
            check("w_cycles", w_cyc, 1);
            void'(exp_w.pop_front());
            w_cyc = 0;
          end
        end
        if (ar_fire) begin
          if (exp_ar.size() == 0) check("ar_unexpected", exp_ar.size(), 1);
          else check("araddr", m_axil.araddr, exp_ar.pop_front());
        end
      end
    end
  end

  // ---------------- ack monitor ----------------
  always @(negedge clk) begin
    if (!rst && req_ack != 2'b00) begin
      n_acks++;
      last_ack_cyc = cyc;
      if (exp_ack.size() == 0) check("ack_unexpected", req_ack, 2'b00);
      else check("ack_grant", req_ack, exp_ack.pop_front());
    end
  end

  // ---------------- response monitor ----------------
  rsp_t mon_e;
  always @(negedge clk) begin
    if (!rst && rsp_valid != 2'b00) begin
      if (exp_rsp.size() == 0) check("rsp_unexpected", rsp_valid, 2'b00);
      else begin
        mon_e = exp_rsp.pop_front();
        check("rsp_valid", rsp_valid, mon_e.who);
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_resp",  rsp_resp,  mon_e.resp);
        if (mon_e.lat != 0) check("rsp_latency", cyc - last_ack_cyc, mon_e.lat);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [1:0] onehot(input int idx);
    return (idx == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [SW-1:0] strb);
    req_write[idx]        = wr;
    req_addr[idx*AW +: AW]  = addr;
    req_wdata[idx*DW +: DW] = data;
    req_wstrb[idx*SW +: SW] = strb;
  endtask

  task automatic expect_write(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                              input logic [SW-1:0] strb, input int aw_cycles, input int lat,
                              input logic [1:0] resp);
    exp_ack.push_back(onehot(idx));
    exp_aw.push_back('{addr: addr, cycles: aw_cycles});
    exp_w.push_back('{data: data, strb: strb});
    exp_rsp.push_back('{who: onehot(idx), rdata: '0, resp: resp, lat: lat});
  endtask

  task automatic expect_read(input int idx, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                             input logic [1:0] resp, input int lat);
    exp_ack.push_back(onehot(idx));
    exp_ar.push_back(addr);
    exp_rsp.push_back('{who: onehot(idx), rdata: data, resp: resp, lat: lat});
  endtask

  // Returns 1 ns after the edge that captured the target-th ack.
  task automatic wait_acks(input int target);
    int budget = 200;
    while (n_acks < target && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    if (n_acks < target) check("ack_timeout", n_acks, target);
    #1;
  endtask

  task automatic wait_quiet();
    int budget = 200;
    while ((exp_rsp.size() != 0 || busy) && budget > 0) begin
      @(posedge clk); #1;
      budget--;
    end
    if (budget == 0) check("rsp_timeout", exp_rsp.size(), 0);
  endtask

  task automatic do_req(input int idx, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] data, input logic [SW-1:0] strb);
    set_req(idx, wr, addr, data, strb);
    req_valid[idx] = 1'b1;
    wait_acks(n_acks + 1);
    req_valid[idx] = 1'b0;
    wait_quiet();
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},      busy, 0);
    check({tag, "_req_ack"},   req_ack, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 0);
    check({tag, "_rsp_resp"},  rsp_resp, 0);
    check({tag, "_err_count"}, err_count, 0);
    check({tag, "_awvalid"},   m_axil.awvalid, 0);
    check({tag, "_wvalid"},    m_axil.wvalid, 0);
    check({tag, "_bready"},    m_axil.bready, 0);
    check({tag, "_arvalid"},   m_axil.arvalid, 0);
    check({tag, "_rready"},    m_axil.rready, 0);
    check({tag, "_awaddr"},    m_axil.awaddr, 0);
    check({tag, "_wdata"},     m_axil.wdata, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, got time %0t expected below 500000", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed test sequence ----------------
  initial begin : stim
    int budget;
    repeat (3) @(posedge clk);
    #1 check_reset("por");
    rst = 1'b0;
    @(posedge clk); #1;

    // Single write from requester 0, minimum 3-cycle ack-to-response.
    expect_write(0, 12'h004, 32'hDEADBEEF, 4'hF, 1, 3, 2'b00);
    do_req(0, 1'b1, 12'h004, 32'hDEADBEEF, 4'hF);
    check("wr_err_count", err_count, 0);

    // Single read from requester 1.
    cfg_rdata = 32'h12345678;
    expect_read(1, 12'h008, 32'h12345678, 2'b00, 3);
    do_req(1, 1'b0, 12'h008, '0, '0);

    // Both held: grants alternate 0,1,0,1.
    cfg_rdata = 32'hCAFE0020;
    set_req(0, 1'b1, 12'h010, 32'hA5A50001, 4'h3);
    set_req(1, 1'b0, 12'h020, '0, '0);
    for (int k = 0; k < 2; k++) begin
      expect_write(0, 12'h010, 32'hA5A50001, 4'h3, 1, 3, 2'b00);
      expect_read(1, 12'h020, 32'hCAFE0020, 2'b00, 3);
    end
    req_valid = 2'b11;
    wait_acks(n_acks + 4);
    req_valid = 2'b00;
    wait_quiet();

    // AW stalled 3 cycles while W is accepted at once.
    cfg_aw_stall = 3;
    expect_write(0, 12'h0FC, 32'h0BADF00D, 4'h5, 4, 6, 2'b00);
    do_req(0, 1'b1, 12'h0FC, 32'h0BADF00D, 4'h5);
    cfg_aw_stall = 0;

    // DECERR on reads: three, then enough more to saturate at 255.
    cfg_rresp = 2'b11;
    cfg_rdata = 32'h0000DEC0;
    for (int k = 0; k < 3; k++) begin
      expect_read(1, 12'h100, 32'h0000DEC0, 2'b11, 3);
      do_req(1, 1'b0, 12'h100, '0, '0);
    end
    check("err_count_3", err_count, 3);
    for (int k = 0; k < 257; k++) begin
      expect_read(0, 12'h104, 32'h0000DEC0, 2'b11, 0);
      do_req(0, 1'b0, 12'h104, '0, '0);
    end
    check("err_count_sat", err_count, 255);
    cfg_rresp = 2'b00;

    // Reset while waiting in WR_RESP with bvalid low.
    cfg_b_block = 1'b1;
    exp_ack.push_back(2'b01);
    exp_aw.push_back('{addr: 12'h200, cycles: 1});
    exp_w.push_back('{data: 32'h11112222, strb: 4'hF});
    set_req(0, 1'b1, 12'h200, 32'h11112222, 4'hF);
    req_valid[0] = 1'b1;
    wait_acks(n_acks + 1);
    req_valid[0] = 1'b0;
    budget = 50;
    while (!m_axil.bready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    check("reach_wr_resp", m_axil.bready, 1);
    #2 rst = 1'b1;
    #1 check_reset("mid");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cfg_b_block = 1'b0;
    @(posedge clk); #1;

    // After reset, a tie goes to requester 0 first, then 1.
    cfg_rdata = 32'h0F0F0F0F;
    set_req(0, 1'b1, 12'h300, 32'h33334444, 4'hC);
    set_req(1, 1'b0, 12'h304, '0, '0);
    expect_write(0, 12'h300, 32'h33334444, 4'hC, 1, 3, 2'b00);
    expect_read(1, 12'h304, 32'h0F0F0F0F, 2'b00, 3);
    req_valid = 2'b11;
    wait_acks(n_acks + 2);
    req_valid = 2'b00;
    wait_quiet();
    check("post_rst_err_count", err_count, 0);

    repeat (3) @(posedge clk);
    check("left_ack", exp_ack.size(), 0);
    check("left_rsp", exp_rsp.size(), 0);
    check("left_aw",  exp_aw.size(), 0);
    check("left_w",   exp_w.size(), 0);
    check("left_ar",  exp_ar.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/axil_master_arbiter.md
# axil_master_arbiter

Two-requester AXI-Lite master arbiter. Two internal register-access requesters (e.g. host bridge, config sequencer) share a single AXI-Lite master port that drives register-file slaves. The block runs round-robin arbitration and allows one outstanding transaction at a time. It sequences the AW/W/B and AR/R channels, returns read data and response to the granted requester, and counts error responses.

## Interface
Parameters:
- ADDR_WIDTH, 12, AXI-Lite address width
- DATA_WIDTH, 32, data width; STRB = DATA_WIDTH/8

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  2  per-requester request; held with payload until req_ack
- req_write  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_WIDTH  requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_wdata  in  2*DATA_WIDTH  packed likewise
- req_wstrb  in  2*STRB  packed likewise
- req_ack  out  2  one-cycle pulse; payload of requester i captured this edge
- rsp_valid  out  2  one-cycle pulse; transaction of requester i complete
- rsp_rdata  out  DATA_WIDTH  read data, valid with rsp_valid (0 for writes)
- rsp_resp  out  2  BRESP/RRESP, valid with rsp_valid
- busy  out  1  state != IDLE
- err_count  out  8  saturating count of non-OKAY responses
- m_axil_awaddr/awvalid/awready, m_axil_wdata/wstrb/wvalid/wready, m_axil_bresp/bvalid/bready, m_axil_araddr/arvalid/arready, m_axil_rdata/rresp/rvalid/rready: standard AXI-Lite master, widths per parameters

## Operation
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE.
- IDLE: if any req_valid, pick grant, capture addr/wdata/wstrb/write into holding registers. req_ack[grant] is combinational = (state==IDLE) & grant one-hot, so the pulse coincides with the capture edge. Next state is WR_REQ or RD_REQ.
- Arbitration: only one valid, grant it. Both valid, grant the requester != last_grant. last_grant updates on capture and resets to 1, so requester 0 wins the first tie.
- WR_REQ: awvalid and wvalid assert together. Each drops independently after its own handshake and is never re-asserted. Go to WR_RESP when both handshakes are done; this includes the case where both complete on the same edge.
- WR_RESP: bready = 1. On bvalid, latch bresp, set rdata_hold = 0, go to DONE.
- RD_REQ: arvalid = 1 until arready, then go to RD_DATA.
- RD_DATA: rready = 1. On rvalid, latch rdata/rresp, go to DONE.
- DONE: rsp_valid[grant] = 1 for exactly this cycle, with rsp_rdata/rsp_resp driven from the latches. Return to IDLE.
- AXI payload outputs (awaddr/wdata/wstrb/araddr) come from the holding registers and are stable while the corresponding valid is high.
- err_count increments by 1 in the cycle a latched response is != 2'b00, and saturates at 255.
- New requests are ignored outside IDLE; req_valid is simply held.
- Reset (async, any state): state is IDLE, all AXI valids and readies are 0, req_ack/rsp_valid are 0, rsp_rdata/rsp_resp are 0, holding registers are 0, err_count is 0, last_grant is 1, busy is 0. An interrupted transaction produces no rsp_valid.

## Timing
- Capture edge is T0. AW/W or AR is presented in cycle T0+1.
- Write with awready=wready=1 and bvalid in the cycle after the W handshake:
  - handshake at T1
  - WR_RESP at T2
  - B at T2
  - DONE, rsp_valid at T3
  - IDLE at T4
  - Minimum period is 4 cycles per transaction.
- Read with arready=1 and rvalid one cycle later: same 4-cycle minimum.
- No combinational path from any AXI input to any AXI output. bready/rready depend on state only.
- Back-to-back requests: the next capture can occur in the first IDLE cycle after DONE.

## Test plan
- Single write: req0 writes addr 0x004, data 0xDEADBEEF, strb 0xF, against a slave that is always ready. Expect one AW and one W beat carrying those values, rsp_valid[0] at T3 with resp 00, and err_count 0.
- Single read: req1 reads 0x008 and the slave returns 0x12345678 OKAY. Expect rsp_valid[1] with rsp_rdata 0x12345678 and no pulse on rsp_valid[0].
- Simultaneous, persistent: req0 and req1 both held valid. Expect grants in the order 0, 1, 0, 1, with req_ack pulses alternating and each completing before the next capture.
- Channel skew: wready=1 and awready held 0 for 3 cycles. Expect wvalid to drop after 1 cycle, awvalid to hold for 4 cycles with stable awaddr, and B to be accepted afterwards.
- Errors: the slave returns DECERR on 3 consecutive reads. Expect rsp_resp 11 each time and err_count 3; after forcing 260 errors, err_count holds at 255.
- Reset mid-write: assert rst in WR_RESP while bvalid is low. Expect all outputs at reset values in the same cycle, no rsp_valid, and the next request granted normally after rst deasserts.
